// File: rtl/alu_slice_sequencer_if.sv
// Request-side bundle between a microcode requester and the ALU slice sequencer.
// The master drives the request and operands; the slave (the sequencer) returns status and result.
interface alu_slice_sequencer_if #(
    parameter int NIBBLES = 9
);
    logic                   start;
    logic [3:0]             op_s;
    logic                   op_m;
    logic                   op_cin;
    logic [4*NIBBLES-1:0]   a;
    logic [4*NIBBLES-1:0]   b;
    logic                   busy;
    logic                   done;
    logic [4*NIBBLES-1:0]   result;
    logic                   cout;
    logic                   zero;

    modport master (
        output start, op_s, op_m, op_cin, a, b,
        input  busy, done, result, cout, zero
    );

    modport slave (
        input  start, op_s, op_m, op_cin, a, b,
        output busy, done, result, cout, zero
    );
endinterface

// File: rtl/alu_slice_sequencer.sv
// Runs one wide ALU operation through a single shared 4-bit slice, one nibble per
// cycle (least-significant first), rippling the carry through a register between nibbles.
module alu_slice_sequencer #(
    parameter int NIBBLES = 9,
    parameter int CNTW    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_slice_sequencer_if.slave bus,
    output logic [3:0]           alu_s,
    output logic                 alu_m,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic                 alu_cin,
    input  logic [3:0]           alu_f,
    input  logic                 alu_cout
);
    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic             carry_q;
    logic [3:0]       s_q;
    logic             m_q;
    logic             cin_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     result_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    // Sequencer FSM: operand latching, per-nibble capture, carry chaining and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            carry_q  <= 1'b0;
            s_q      <= '0;
            m_q      <= 1'b0;
            cin_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        s_q    <= bus.op_s;
                        m_q    <= bus.op_m;
                        cin_q  <= bus.op_cin;
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Result is overwritten in place; earlier nibbles of the old result
                    // stay visible until their slot comes round.
                    result_q[4*int'(cnt) +: 4] <= alu_f;
                    carry_q <= alu_cout;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNTW'(NIBBLES - 1)) begin
                        cout_q <= alu_cout;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Slice operand steering: current nibble during RUN, held at zero otherwise
    always_comb begin
        alu_a   = 4'h0;
        alu_b   = 4'h0;
        alu_cin = 1'b0;
        if (state == RUN) begin
            alu_a   = a_q[4*int'(cnt) +: 4];
            alu_b   = b_q[4*int'(cnt) +: 4];
            alu_cin = (cnt == '0) ? cin_q : carry_q;
        end
    end

    assign alu_s      = s_q;
    assign alu_m      = m_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.zero   = (result_q == '0);
endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer: behavioural 4-bit slice, directed operations,
// expectations queued at issue time and checked by a separate done monitor.
module tb_alu_slice_sequencer;
    localparam int NIB = 9;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_s;
    logic        alu_m;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic        alu_cin;
    logic [3:0]  alu_f;
    logic        alu_cout;

    alu_slice_sequencer_if #(.NIBBLES(NIB)) bus ();

    alu_slice_sequencer #(.NIBBLES(NIB), .CNTW(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .alu_s    (alu_s),
        .alu_m    (alu_m),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_f    (alu_f),
        .alu_cout (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slice: only the functions exercised here
    logic [4:0] sum5;
    logic [3:0] nb;
    always_comb begin
        sum5     = 5'd0;
        nb       = ~alu_b;
        alu_f    = 4'h0;
        alu_cout = 1'b0;
        if (alu_m) begin
            if (alu_s == 4'b1001) alu_f = alu_a ^ alu_b;
        end else begin
            if (alu_s == 4'b0110)
                sum5 = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
            else if (alu_s == 4'b1001)
                sum5 = {1'b0, alu_a} + {1'b0, nb} + {4'b0, alu_cin};
            alu_f    = sum5[3:0];
            alu_cout = sum5[4];
        end
    end

    typedef struct packed {
        logic [7:0]  id;
        logic [35:0] result;
        logic        cout;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   busy_cnt = 0;

    task automatic check(input string name, input int id, input logic [35:0] act, input logic [35:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s op%0d: got %h expected %h", name, id, act, req);
        end
    endtask

    // Monitor: counts busy cycles and checks each done against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got result %h expected no done", bus.result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", int'(e.id), bus.result, e.result);
                    check("cout", int'(e.id), 36'(bus.cout), 36'(e.cout));
                    check("zero", int'(e.id), 36'(bus.zero), 36'(e.zero));
                    check("busy_cycles", int'(e.id), 36'(busy_cnt), 36'(NIB));
                end
                busy_cnt = 0;
            end
        end
    end

    // Issue one start pulse; optionally queue the expected response. Inputs are
    // scrambled right after the start edge to show they are not used afterwards.
    task automatic issue(input logic [3:0] s, input logic m, input logic cin,
                         input logic [35:0] av, input logic [35:0] bv, input logic push,
                         input logic [35:0] er, input logic ec, input logic [7:0] id);
        exp_t e;
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.op_s   = s;
        bus.op_m   = m;
        bus.op_cin = cin;
        bus.a      = av;
        bus.b      = bv;
        if (push) begin
            e.id     = id;
            e.result = er;
            e.cout   = ec;
            e.zero   = (er == 36'h0);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.op_s   = ~s;
        bus.op_m   = ~m;
        bus.op_cin = ~cin;
        bus.a      = ~av;
        bus.b      = ~bv;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got %0d pending expected 0 pending", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_s   = 4'h0;
        bus.op_m   = 1'b0;
        bus.op_cin = 1'b0;
        bus.a      = 36'h0;
        bus.b      = 36'h0;
        #12;
        check("rst_busy", 0, 36'(bus.busy), 36'h0);
        check("rst_done", 0, 36'(bus.done), 36'h0);
        check("rst_result", 0, bus.result, 36'h0);
        check("rst_cout", 0, 36'(bus.cout), 36'h0);
        check("rst_zero", 0, 36'(bus.zero), 36'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Add with a single internal carry
        issue(4'b0110, 1'b0, 1'b0, 36'h0_0000_000F, 36'h0_0000_0001, 1'b1, 36'h0_0000_0010, 1'b0, 8'd1);
        wait_idle();
        // Carry rippling through every nibble
        issue(4'b0110, 1'b0, 1'b1, 36'hF_FFFF_FFFF, 36'h0, 1'b1, 36'h0, 1'b1, 8'd2);
        wait_idle();
        // Subtract with borrow, then without
        issue(4'b1001, 1'b0, 1'b1, 36'h5, 36'h7, 1'b1, 36'hF_FFFF_FFFE, 1'b0, 8'd3);
        wait_idle();
        issue(4'b1001, 1'b0, 1'b1, 36'h7, 36'h5, 1'b1, 36'h2, 1'b1, 8'd4);
        wait_idle();
        // Logic XOR
        issue(4'b1001, 1'b1, 1'b0, 36'hA_5A5A_5A5A, 36'hF_0F0F_0F0F, 1'b1, 36'h5_5555_5555, 1'b0, 8'd5);
        wait_idle();

        // Second start during RUN must be ignored
        issue(4'b0110, 1'b0, 1'b0, 36'h1_2345_6789, 36'h1_1111_1111, 1'b1, 36'h2_3456_789A, 1'b0, 8'd6);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op_s  = 4'b0110;
        bus.op_m  = 1'b0;
        bus.a     = 36'hF_FFFF_FFFF;
        bus.b     = 36'h1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();
        repeat (NIB + 3) @(posedge clk);

        // Asynchronous reset in the middle of an operation
        issue(4'b0110, 1'b0, 1'b1, 36'hF_FFFF_FFFF, 36'h0, 1'b0, 36'h0, 1'b0, 8'd0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 7, 36'(bus.busy), 36'h0);
        check("abort_done", 7, 36'(bus.done), 36'h0);
        check("abort_result", 7, bus.result, 36'h0);
        check("abort_cout", 7, 36'(bus.cout), 36'h0);
        check("abort_zero", 7, 36'(bus.zero), 36'h1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fresh operation after reset
        issue(4'b0110, 1'b0, 1'b0, 36'hF_EDCB_A987, 36'h0_0000_0079, 1'b1, 36'hF_EDCB_AA00, 1'b0, 8'd8);
        wait_idle();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_slice_sequencer.md
Name: alu_slice_sequencer

Overview:
- Performs one 36-bit ALU operation per request using a single shared 4-bit MC10181-style ALU slice.
- Iterates over 9 nibbles, least-significant first, and ripples the carry through a register between nibbles.
- Sits between microcode-level requesters and one ALU slice instance in designs where area matters more than speed.
- Owns operand and result registers, nibble sequencing, carry chaining and the start/busy/done handshake.

Parameters:
- NIBBLES, 9: number of 4-bit nibbles per operation; word width is 4*NIBBLES.
- CNTW, 4: width of the nibble counter; must satisfy 2**CNTW >= NIBBLES.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op_s  input  4  slice function select S[3:0], latched at start.
- op_m  input  1  slice mode, latched at start: 1 = logic, 0 = arithmetic.
- op_cin  input  1  carry into nibble 0, active-high, latched at start.
- a  input  4*NIBBLES  operand A, latched at start.
- b  input  4*NIBBLES  operand B, latched at start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  4*NIBBLES  result register; holds its value until the next accepted start.
- cout  output  1  carry out of the last nibble, registered.
- zero  output  1  high when result == 0; combinational from the result register.
- alu_s  output  4  to slice S, from the latched op_s.
- alu_m  output  1  to slice M, from the latched op_m.
- alu_a  output  4  to slice A, current nibble of latched A; bit 3 is the MSB.
- alu_b  output  4  to slice B, current nibble of latched B.
- alu_cin  output  1  to slice CIN.
- alu_f  input  4  slice F.
- alu_cout  input  1  slice COUT, active-high carry.

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free.
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE, counter = 0, carry register = 0.
  - busy = 0, done = 0, result = 0, cout = 0, zero = 1.
  - Latched operands and function = 0.
- IDLE:
  - start = 1 at an edge latches op_s, op_m, op_cin, a and b.
  - At the same edge: counter = 0, state goes to RUN, busy = 1.
  - result is not cleared at start; it is overwritten nibble by nibble.
- RUN, counter = n:
  - alu_a = A_q[4n+3:4n] and alu_b = B_q[4n+3:4n], combinationally from the counter.
  - alu_cin = op_cin_q when n = 0; otherwise the carry register.
  - At each edge: result[4n+3:4n] = alu_f, carry register = alu_cout, counter increments.
- Last nibble (n = NIBBLES-1):
  - At its capture edge, cout is loaded from alu_cout.
  - State goes to DONE: busy = 0, done = 1.
- DONE:
  - Lasts exactly one cycle, then IDLE and done = 0.
- Latency: with start sampled at edge k, done is high for the cycle after edge k+NIBBLES. Minimum start-to-start spacing is NIBBLES+2 cycles.
- start in RUN or DONE is ignored. No queueing and no effect on the latched operands.
- Operand and op_* changes after the start edge have no effect on the current operation.
- In logic mode (op_m = 1) the carry is still chained and cout still registered. The slice ignores carry in that mode, so result is the bitwise function.
- Subtraction uses S = 1001 with op_cin = 1, giving A-B. cout = 1 means no borrow.
- Outside RUN, alu_a/alu_b/alu_cin are don't-care but must be driven to a known value (0).
- The block does not use the slice's CG/CP outputs.

Test Plan:
- Add: S=0110, M=0, cin=0, a=36'h0_0000_000F, b=36'h1.
  - Required: busy for 9 cycles, done one cycle later.
  - result = 36'h0_0000_0010, cout = 0, zero = 0.
- Ripple wrap: S=0110, M=0, cin=1, a=36'hF_FFFF_FFFF, b=0.
  - Required: result = 0, cout = 1, zero = 1. The carry must pass through all 9 nibbles.
- Subtract: S=1001, M=0, cin=1.
  - a=5, b=7: result = 36'hF_FFFF_FFFE, cout = 0.
  - a=7, b=5: result = 2, cout = 1.
- Logic XOR: S=1001, M=1, a=36'hA_5A5A_5A5A, b=36'hF_0F0F_0F0F.
  - Required: result = 36'h5_5555_5555.
- Handshake and reset:
  - Start pulsed again during RUN: ignored, result unchanged from the first operation.
  - rst_n low at nibble 4: busy, done and result go to 0 immediately, state IDLE. A new start after reset completes normally.
